// File: rtl/lht_update_ctrl.sv
// rtl/lht_update_ctrl.sv - LHT update0 scheduler: two-port in-order update queue with coalescing, drain gating and flush.
module lht_update_ctrl #(
  parameter int UPDQ_DEPTH  = 8,
  parameter bit COALESCE_EN = 1'b1,
  parameter int LH_LENGTH   = 8,
  parameter int ASID_WIDTH  = 8,
  localparam int CW = $clog2(UPDQ_DEPTH + 1)
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  enq0_valid,
  input  logic [31:0]           enq0_start_full_PC,
  input  logic [ASID_WIDTH-1:0] enq0_ASID,
  input  logic [LH_LENGTH-1:0]  enq0_lh,
  output logic                  enq0_ready,
  input  logic                  enq1_valid,
  input  logic [31:0]           enq1_start_full_PC,
  input  logic [ASID_WIDTH-1:0] enq1_ASID,
  input  logic [LH_LENGTH-1:0]  enq1_lh,
  output logic                  enq1_ready,
  input  logic                  drain_en,
  input  logic                  flush,
  output logic [CW-1:0]         occupancy,
  output logic                  update0_valid,
  output logic [31:0]           update0_start_full_PC,
  output logic [ASID_WIDTH-1:0] update0_ASID,
  output logic [LH_LENGTH-1:0]  update0_lh
);

  localparam int PW = $clog2(UPDQ_DEPTH);
  localparam int KW = 31 + ASID_WIDTH;

  logic [PW-1:0]         head;
  logic [PW-1:0]         tail;
  logic [CW-1:0]         count;
  logic [UPDQ_DEPTH-1:0] ent_valid;
  logic [31:0]           ent_pc   [UPDQ_DEPTH];
  logic [ASID_WIDTH-1:0] ent_asid [UPDQ_DEPTH];
  logic [LH_LENGTH-1:0]  ent_lh   [UPDQ_DEPTH];

  logic [CW-1:0]        free_slots;
  logic [KW-1:0]        key0;
  logic [KW-1:0]        key1;
  logic                 acc0;
  logic                 acc1;
  logic                 deq;
  logic                 hit0;
  logic                 hit1;
  logic [PW-1:0]        idx0;
  logic [PW-1:0]        idx1;
  logic                 same01;
  logic                 wr0;
  logic                 wr1;
  logic                 alloc0;
  logic                 alloc1;
  logic [PW-1:0]        slot0;
  logic [PW-1:0]        slot1;
  logic [LH_LENGTH-1:0] lh0;
  logic [CW-1:0]        n_alloc;

  // Ready looks only at the registered count so it never depends on valid or dequeue.
  assign free_slots = CW'(UPDQ_DEPTH) - count;
  assign enq0_ready = !RST && (free_slots >= CW'(1));
  assign enq1_ready = !RST && (free_slots >= CW'(2));
  assign occupancy  = count;

  assign key0 = {enq0_start_full_PC[31:1], enq0_ASID};
  assign key1 = {enq1_start_full_PC[31:1], enq1_ASID};
  assign acc0 = enq0_valid && enq0_ready && !flush;
  assign acc1 = enq1_valid && enq1_ready && !flush;
  assign deq  = drain_en && (count != '0) && !flush;

  // The head entry leaving this cycle is not a coalescing target; a same-key request reallocates.
  always_comb begin
    hit0 = 1'b0;
    hit1 = 1'b0;
    idx0 = '0;
    idx1 = '0;
    for (int i = 0; i < UPDQ_DEPTH; i++) begin
      if (COALESCE_EN && ent_valid[i] && !(deq && (head == PW'(i)))) begin
        if ({ent_pc[i][31:1], ent_asid[i]} == key0) begin
          hit0 = 1'b1;
          idx0 = PW'(i);
        end
        if ({ent_pc[i][31:1], ent_asid[i]} == key1) begin
          hit1 = 1'b1;
          idx1 = PW'(i);
        end
      end
    end
  end

  // Same-key pair in one cycle collapses into a single write carrying the younger lh.
  always_comb begin
    same01  = COALESCE_EN && acc0 && acc1 && (key0 == key1);
    wr0     = acc0;
    wr1     = acc1 && !same01;
    alloc0  = wr0 && !hit0;
    alloc1  = wr1 && !hit1;
    lh0     = same01 ? enq1_lh : enq0_lh;
    slot0   = hit0 ? idx0 : tail;
    slot1   = hit1 ? idx1 : (alloc0 ? tail + PW'(1) : tail);
    n_alloc = CW'(alloc0) + CW'(alloc1);
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      head      <= '0;
      tail      <= '0;
      count     <= '0;
      ent_valid <= '0;
    end else if (flush) begin
      head      <= '0;
      tail      <= '0;
      count     <= '0;
      ent_valid <= '0;
    end else begin
      if (deq) begin
        ent_valid[head] <= 1'b0;
        head            <= head + PW'(1);
      end
      if (wr0) begin
        ent_lh[slot0] <= lh0;
        if (alloc0) begin
          ent_valid[slot0] <= 1'b1;
          ent_pc[slot0]    <= enq0_start_full_PC;
          ent_asid[slot0]  <= enq0_ASID;
        end
      end
      if (wr1) begin
        ent_lh[slot1] <= enq1_lh;
        if (alloc1) begin
          ent_valid[slot1] <= 1'b1;
          ent_pc[slot1]    <= enq1_start_full_PC;
          ent_asid[slot1]  <= enq1_ASID;
        end
      end
      tail  <= tail + PW'(n_alloc);
      count <= count + n_alloc - CW'(deq);
    end
  end

  // Output data holds its last value between strobes.
  always_ff @(posedge CLK) begin
    if (RST) begin
      update0_valid         <= 1'b0;
      update0_start_full_PC <= '0;
      update0_ASID          <= '0;
      update0_lh            <= '0;
    end else begin
      update0_valid <= deq;
      if (deq) begin
        update0_start_full_PC <= ent_pc[head];
        update0_ASID          <= ent_asid[head];
        update0_lh            <= ent_lh[head];
      end
    end
  end

endmodule

// File: tb/tb_lht_update_ctrl.sv
// tb/tb_lht_update_ctrl.sv - directed self-checking bench for lht_update_ctrl.
module tb_lht_update_ctrl;

  logic        CLK;
  logic        RST;
  logic        enq0_valid;
  logic [31:0] enq0_start_full_PC;
  logic [7:0]  enq0_ASID;
  logic [7:0]  enq0_lh;
  logic        enq1_valid;
  logic [31:0] enq1_start_full_PC;
  logic [7:0]  enq1_ASID;
  logic [7:0]  enq1_lh;
  logic        drain_en;
  logic        flush;

  logic        enq0_ready;
  logic        enq1_ready;
  logic [3:0]  occupancy;
  logic        update0_valid;
  logic [31:0] update0_start_full_PC;
  logic [7:0]  update0_ASID;
  logic [7:0]  update0_lh;

  logic        nc_enq0_ready;
  logic        nc_enq1_ready;
  logic [3:0]  nc_occupancy;
  logic        nc_update0_valid;
  logic [31:0] nc_update0_start_full_PC;
  logic [7:0]  nc_update0_ASID;
  logic [7:0]  nc_update0_lh;

  int n_checks = 0;
  int n_fail   = 0;

  lht_update_ctrl #(.UPDQ_DEPTH(8), .COALESCE_EN(1'b1), .LH_LENGTH(8), .ASID_WIDTH(8)) dut (
    .CLK(CLK), .RST(RST),
    .enq0_valid(enq0_valid), .enq0_start_full_PC(enq0_start_full_PC), .enq0_ASID(enq0_ASID),
    .enq0_lh(enq0_lh), .enq0_ready(enq0_ready),
    .enq1_valid(enq1_valid), .enq1_start_full_PC(enq1_start_full_PC), .enq1_ASID(enq1_ASID),
    .enq1_lh(enq1_lh), .enq1_ready(enq1_ready),
    .drain_en(drain_en), .flush(flush), .occupancy(occupancy),
    .update0_valid(update0_valid), .update0_start_full_PC(update0_start_full_PC),
    .update0_ASID(update0_ASID), .update0_lh(update0_lh)
  );

  lht_update_ctrl #(.UPDQ_DEPTH(8), .COALESCE_EN(1'b0), .LH_LENGTH(8), .ASID_WIDTH(8)) dut_nc (
    .CLK(CLK), .RST(RST),
    .enq0_valid(enq0_valid), .enq0_start_full_PC(enq0_start_full_PC), .enq0_ASID(enq0_ASID),
    .enq0_lh(enq0_lh), .enq0_ready(nc_enq0_ready),
    .enq1_valid(enq1_valid), .enq1_start_full_PC(enq1_start_full_PC), .enq1_ASID(enq1_ASID),
    .enq1_lh(enq1_lh), .enq1_ready(nc_enq1_ready),
    .drain_en(drain_en), .flush(flush), .occupancy(nc_occupancy),
    .update0_valid(nc_update0_valid), .update0_start_full_PC(nc_update0_start_full_PC),
    .update0_ASID(nc_update0_ASID), .update0_lh(nc_update0_lh)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic idle();
    enq0_valid = 1'b0;
    enq1_valid = 1'b0;
    flush      = 1'b0;
  endtask

  task automatic set0(input logic [31:0] pc, input logic [7:0] asid, input logic [7:0] lh);
    enq0_valid         = 1'b1;
    enq0_start_full_PC = pc;
    enq0_ASID          = asid;
    enq0_lh            = lh;
  endtask

  task automatic set1(input logic [31:0] pc, input logic [7:0] asid, input logic [7:0] lh);
    enq1_valid         = 1'b1;
    enq1_start_full_PC = pc;
    enq1_ASID          = asid;
    enq1_lh            = lh;
  endtask

  task automatic do_reset();
    idle();
    drain_en = 1'b0;
    RST = 1'b1;
    step();
    step();
    RST = 1'b0;
  endtask

  task automatic expect_write(input string tag, input logic [31:0] pc, input logic [7:0] asid,
                              input logic [7:0] lh);
    check({tag, " valid"}, update0_valid, 1'b1);
    check({tag, " pc"}, update0_start_full_PC, pc);
    check({tag, " asid"}, update0_ASID, asid);
    check({tag, " lh"}, update0_lh, lh);
  endtask

  initial begin
    RST = 1'b1;
    drain_en = 1'b0;
    idle();
    enq0_start_full_PC = '0; enq0_ASID = '0; enq0_lh = '0;
    enq1_start_full_PC = '0; enq1_ASID = '0; enq1_lh = '0;

    // Reset holds ready low even with a valid request present
    set0(32'h1000, 8'd3, 8'hA5);
    #1;
    check("rst enq0_ready", enq0_ready, 1'b0);
    check("rst enq1_ready", enq1_ready, 1'b0);
    step();
    check("rst update0_valid", update0_valid, 1'b0);
    step();
    check("rst enq0_ready 2", enq0_ready, 1'b0);
    RST = 1'b0;
    idle();
    #1;
    check("post-rst occupancy", occupancy, 4'd0);
    check("post-rst enq0_ready", enq0_ready, 1'b1);
    check("post-rst enq1_ready", enq1_ready, 1'b1);

    // Single update latency
    drain_en = 1'b1;
    set0(32'h1000, 8'd3, 8'hA5);
    step();
    idle();
    check("lat occ N+1", occupancy, 4'd1);
    check("lat valid N+1", update0_valid, 1'b0);
    step();
    expect_write("lat N+2", 32'h1000, 8'd3, 8'hA5);
    check("lat occ N+2", occupancy, 4'd0);
    step();
    check("lat valid pulse end", update0_valid, 1'b0);

    // Coalescing while drain held; non-coalescing instance allocates all three
    do_reset();
    set0(32'h2004, 8'd1, 8'h11); step();
    set0(32'h2004, 8'd1, 8'h22); step();
    set0(32'h2004, 8'd2, 8'h33); step();
    idle();
    check("coal occ", occupancy, 4'd2);
    check("nocoal occ", nc_occupancy, 4'd3);
    check("coal hold valid", update0_valid, 1'b0);
    drain_en = 1'b1;
    step();
    expect_write("coal w0", 32'h2004, 8'd1, 8'h22);
    step();
    expect_write("coal w1", 32'h2004, 8'd2, 8'h33);
    step();
    check("coal no extra", update0_valid, 1'b0);

    // Same-cycle same key: one entry, younger lh
    do_reset();
    set0(32'h3000, 8'd5, 8'h44);
    set1(32'h3000, 8'd5, 8'h55);
    step();
    idle();
    check("pair same occ", occupancy, 4'd1);
    drain_en = 1'b1;
    step();
    expect_write("pair same", 32'h3000, 8'd5, 8'h55);
    step();
    check("pair same single", update0_valid, 1'b0);

    // Same-cycle distinct keys: port 0 first
    drain_en = 1'b0;
    set0(32'h4000, 8'd1, 8'h66);
    set1(32'h4010, 8'd1, 8'h77);
    step();
    idle();
    check("pair diff occ", occupancy, 4'd2);
    drain_en = 1'b1;
    step();
    expect_write("pair diff w0", 32'h4000, 8'd1, 8'h66);
    step();
    expect_write("pair diff w1", 32'h4010, 8'd1, 8'h77);

    // PC bit 0 is not part of the key; original PC retained
    drain_en = 1'b0;
    set0(32'h5000, 8'd9, 8'h01); step();
    set0(32'h5001, 8'd9, 8'h02); step();
    idle();
    check("pc0 occ", occupancy, 4'd1);
    drain_en = 1'b1;
    step();
    expect_write("pc0", 32'h5000, 8'd9, 8'h02);

    // Entry leaving this cycle is not a coalescing target
    drain_en = 1'b0;
    set0(32'h2800, 8'd4, 8'h01); step();
    drain_en = 1'b1;
    set0(32'h2800, 8'd4, 8'h02); step();
    idle();
    expect_write("deq excl w0", 32'h2800, 8'd4, 8'h01);
    check("deq excl occ", occupancy, 4'd1);
    step();
    expect_write("deq excl w1", 32'h2800, 8'd4, 8'h02);
    check("deq excl occ0", occupancy, 4'd0);

    // Fill, ready boundaries, partial drain, wrap
    do_reset();
    for (int i = 0; i < 7; i++) begin
      set0(32'h6000 + 32'(i * 16), 8'd7, 8'h80 + 8'(i));
      step();
    end
    idle();
    check("fill7 occ", occupancy, 4'd7);
    check("fill7 enq0_ready", enq0_ready, 1'b1);
    check("fill7 enq1_ready", enq1_ready, 1'b0);
    set0(32'h6070, 8'd7, 8'h87);
    step();
    idle();
    check("fill8 occ", occupancy, 4'd8);
    check("fill8 enq0_ready", enq0_ready, 1'b0);
    check("fill8 enq1_ready", enq1_ready, 1'b0);
    drain_en = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      expect_write($sformatf("part w%0d", i), 32'h6000 + 32'(i * 16), 8'd7, 8'h80 + 8'(i));
    end
    check("part occ", occupancy, 4'd5);
    drain_en = 1'b0;
    for (int i = 8; i < 11; i++) begin
      set0(32'h6000 + 32'(i * 16), 8'd7, 8'h80 + 8'(i));
      step();
    end
    idle();
    check("wrap occ", occupancy, 4'd8);
    drain_en = 1'b1;
    for (int i = 3; i < 11; i++) begin
      step();
      expect_write($sformatf("wrap w%0d", i), 32'h6000 + 32'(i * 16), 8'd7, 8'h80 + 8'(i));
    end
    check("wrap occ end", occupancy, 4'd0);

    // Flush wins over drain and enqueue
    do_reset();
    for (int i = 0; i < 5; i++) begin
      set0(32'h9000 + 32'(i * 4), 8'd2, 8'h10 + 8'(i));
      step();
    end
    idle();
    check("flush pre occ", occupancy, 4'd5);
    drain_en = 1'b1;
    flush = 1'b1;
    set0(32'h7770, 8'd1, 8'hEE);
    step();
    idle();
    check("flush occ", occupancy, 4'd0);
    check("flush valid", update0_valid, 1'b0);
    check("flush enq0_ready", enq0_ready, 1'b1);
    step();
    check("flush drop 1", update0_valid, 1'b0);
    step();
    check("flush drop 2", update0_valid, 1'b0);

    // Reset mid-operation drops queued entries
    drain_en = 1'b0;
    set0(32'hA000, 8'd1, 8'h01); step();
    set0(32'hA004, 8'd1, 8'h02); step();
    idle();
    check("midrst pre occ", occupancy, 4'd2);
    RST = 1'b1;
    step();
    RST = 1'b0;
    drain_en = 1'b1;
    check("midrst occ", occupancy, 4'd0);
    step();
    check("midrst valid", update0_valid, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
